// File: rtl/mem_pkg.sv
// Shared types and default sizing for the cache refill arbiter.
package mem_pkg;

    localparam int MEM_LINE_W = 128;
    localparam int MEM_LAT    = 10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef enum logic {
        REQ_IC,
        REQ_DC
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not served last wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic      ic_req,
    input  logic      dc_req,
    input  req_id_t   last,
    output logic [1:0] gnt,
    output req_id_t   winner
);

    // gnt[0] is the icache, gnt[1] the dcache.
    always_comb begin
        winner = REQ_IC;
        gnt    = 2'b00;
        if (ic_req && dc_req) begin
            winner = (last == REQ_IC) ? REQ_DC : REQ_IC;
        end else if (dc_req) begin
            winner = REQ_DC;
        end
        if (ic_req || dc_req) begin
            gnt = (winner == REQ_DC) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Serialises icache/dcache line fills and dcache word writes onto one
// fixed-latency synchronous memory, arbitrating round-robin between the caches.
module mem_refill_arbiter
    import mem_pkg::*;
#(
    parameter int LAT    = MEM_LAT,
    parameter int LINE_W = MEM_LINE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    output logic              ic_gnt,
    output logic              ic_valid,
    output logic [LINE_W-1:0] ic_line,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [31:0]       dc_addr,
    input  logic [31:0]       dc_wd,
    output logic              dc_gnt,
    output logic              dc_valid,
    output logic [LINE_W-1:0] dc_line,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    // LAT=1 needs no count, but keep one bit so the vector stays legal.
    localparam int              CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    mem_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    req_id_t          owner, last;
    logic             we_q;
    logic [31:0]      addr_q, wd_q;

    logic [1:0]       arb_gnt;
    req_id_t          arb_win;
    logic             start, last_beat;

    rr_arb2 u_arb (
        .ic_req (ic_req),
        .dc_req (dc_req),
        .last   (last),
        .gnt    (arb_gnt),
        .winner (arb_win)
    );

    // Grants are combinational but suppressed while reset is held.
    assign start     = (state == IDLE) && reset_n && (arb_gnt != 2'b00);
    assign last_beat = (state == BUSY) && (cnt == '0);

    assign ic_gnt   = start && arb_gnt[0];
    assign dc_gnt   = start && arb_gnt[1];
    assign ic_valid = (state == RESP) && (owner == REQ_IC);
    assign dc_valid = (state == RESP) && (owner == REQ_DC);
    assign mem_req  = (state == BUSY);
    assign mem_we   = last_beat && we_q;
    assign mem_addr = addr_q;
    assign mem_wd   = wd_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            owner   <= REQ_IC;
            last    <= REQ_IC;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            ic_line <= '0;
            dc_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        owner <= arb_win;
                        cnt   <= CNT_LOAD;
                        // Fills are line-aligned; writes keep the word offset.
                        if (arb_win == REQ_DC) begin
                            we_q   <= dc_we;
                            addr_q <= dc_we ? dc_addr : (dc_addr & ~32'hF);
                            wd_q   <= dc_wd;
                        end else begin
                            we_q   <= 1'b0;
                            addr_q <= ic_addr & ~32'hF;
                            wd_q   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!we_q) begin
                        if (owner == REQ_IC) ic_line <= mem_rdata;
                        else                 dc_line <= mem_rdata;
                    end
                end
                RESP: last <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomised and directed bench for mem_refill_arbiter against a cycle-arithmetic
// transaction model with a shadow memory.
module tb_mem_refill_arbiter;
    import mem_pkg::*;

    localparam int LAT    = 10;
    localparam int LINE_W = 128;
    localparam int NLINES = 16;
    typedef logic [LINE_W-1:0] val_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (LAT=10) ----------------
    logic        ic_req = 0, dc_req = 0, dc_we = 0;
    logic [31:0] ic_addr = 0, dc_addr = 0, dc_wd = 0;
    logic        ic_gnt, ic_valid, dc_gnt, dc_valid, mem_req, mem_we, busy;
    val_t        ic_line, dc_line, mem_rdata;
    logic [31:0] mem_addr, mem_wd;

    mem_refill_arbiter #(.LAT(LAT), .LINE_W(LINE_W)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_valid(ic_valid), .ic_line(ic_line),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wd(dc_wd),
        .dc_gnt(dc_gnt), .dc_valid(dc_valid), .dc_line(dc_line),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Backing memory: combinational read, word write on the clock edge.
    val_t mem_arr [NLINES];
    logic mem_fill = 1'b1;
    assign mem_rdata = mem_arr[mem_addr[7:4]];

    function automatic val_t init_line(input int i);
        logic [31:0] b;
        b = 32'h1111_0000 + 32'(i) * 32'h0101;
        return {b ^ 32'hF000_0003, b ^ 32'h0F00_0002, b ^ 32'h00F0_0001, b};
    endfunction

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < NLINES; i++) mem_arr[i] <= init_line(i);
        end else if (mem_req && mem_we) begin
            mem_arr[mem_addr[7:4]][{mem_addr[3:2], 5'b0} +: 32] <= mem_wd;
        end
    end

    // ---------------- second DUT (LAT=1) ----------------
    logic        l_ic_req = 0, l_dc_req = 0, l_dc_we = 0;
    logic [31:0] l_ic_addr = 0, l_dc_addr = 0, l_dc_wd = 0;
    logic        l_ic_gnt, l_ic_valid, l_dc_gnt, l_dc_valid, l_mem_req, l_mem_we, l_busy;
    val_t        l_ic_line, l_dc_line, l_mem_rdata;
    logic [31:0] l_mem_addr, l_mem_wd;

    assign l_mem_rdata = {l_mem_addr, ~l_mem_addr, l_mem_addr ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};

    mem_refill_arbiter #(.LAT(1), .LINE_W(LINE_W)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .ic_req(l_ic_req), .ic_addr(l_ic_addr), .ic_gnt(l_ic_gnt), .ic_valid(l_ic_valid), .ic_line(l_ic_line),
        .dc_req(l_dc_req), .dc_we(l_dc_we), .dc_addr(l_dc_addr), .dc_wd(l_dc_wd),
        .dc_gnt(l_dc_gnt), .dc_valid(l_dc_valid), .dc_line(l_dc_line),
        .mem_req(l_mem_req), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wd(l_mem_wd),
        .mem_rdata(l_mem_rdata), .busy(l_busy)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail = 0;
    val_t ref_mem [NLINES];
    bit   act = 0, g_dc = 0, g_we = 0, last_dc = 0;
    int   g_cyc = 0, free_cyc = 0;
    logic [31:0] g_addr = 0, g_wd = 0;
    val_t g_line = '0, exp_ic_line = '0, exp_dc_line = '0;
    logic [0:0] exp_q[$];
    bit   track_order = 0, ic_hold = 0, dc_hold = 0, rand_mode = 0, saw_ic = 0, saw_dc = 0;
    int   ic_gnt_cyc, ic_val_cyc, dc_gnt_cyc, dc_val_cyc, we_cyc, we_cnt, dcv_cnt;
    logic [31:0] we_addr;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: a granted access occupies cycles g+1..g+LAT on the memory, reports
    // at g+LAT+1 and frees the arbiter from g+LAT+2.
    task automatic step_check();
        logic e_ig, e_dg, e_iv, e_dv, e_mr, e_mw, e_busy;
        {e_ig, e_dg, e_iv, e_dv, e_mr, e_mw, e_busy} = '0;
        if (!reset_n) begin
            act = 0; last_dc = 0; free_cyc = 0;
            exp_ic_line = '0; exp_dc_line = '0;
            check("rst_mem_addr", val_t'(mem_addr), val_t'(0));
            check("rst_mem_wd", val_t'(mem_wd), val_t'(0));
        end else begin
            if (act) begin
                e_mr   = (cyc > g_cyc) && (cyc <= g_cyc + LAT);
                e_busy = (cyc > g_cyc) && (cyc <= g_cyc + LAT + 1);
                if (e_mr) begin
                    check("mem_addr", val_t'(mem_addr), val_t'(g_addr));
                    if (g_we) check("mem_wd", val_t'(mem_wd), val_t'(g_wd));
                end
                if (g_we && cyc == g_cyc + LAT) begin
                    e_mw = 1;
                    ref_mem[g_addr[7:4]][{g_addr[3:2], 5'b0} +: 32] = g_wd;
                end
                if (cyc == g_cyc + LAT + 1) begin
                    if (g_dc) e_dv = 1; else e_iv = 1;
                    if (!g_we) begin
                        if (g_dc) exp_dc_line = g_line; else exp_ic_line = g_line;
                    end
                    last_dc = g_dc;
                    act = 0;
                end
            end
            if (!act && cyc >= free_cyc && (ic_req || dc_req)) begin
                g_dc = dc_req && (!ic_req || !last_dc);
                g_cyc = cyc; free_cyc = cyc + LAT + 2; act = 1;
                g_we = g_dc && dc_we;
                g_wd = g_dc ? dc_wd : 32'h0;
                g_addr = g_dc ? dc_addr : ic_addr;
                if (!g_we) g_addr[3:0] = 4'h0;
                g_line = ref_mem[g_addr[7:4]];
                if (g_dc) e_dg = 1; else e_ig = 1;
            end
        end
        check("ic_gnt", val_t'(ic_gnt), val_t'(e_ig));
        check("dc_gnt", val_t'(dc_gnt), val_t'(e_dg));
        check("ic_valid", val_t'(ic_valid), val_t'(e_iv));
        check("dc_valid", val_t'(dc_valid), val_t'(e_dv));
        check("mem_req", val_t'(mem_req), val_t'(e_mr));
        check("mem_we", val_t'(mem_we), val_t'(e_mw));
        check("busy", val_t'(busy), val_t'(e_busy));
        check("ic_line", ic_line, exp_ic_line);
        check("dc_line", dc_line, exp_dc_line);
        if (ic_gnt) ic_gnt_cyc = cyc;
        if (dc_gnt) dc_gnt_cyc = cyc;
        if (ic_valid) ic_val_cyc = cyc;
        if (dc_valid) begin dc_val_cyc = cyc; dcv_cnt++; end
        if (mem_we) begin we_cyc = cyc; we_cnt++; we_addr = mem_addr; end
        if (track_order && (ic_gnt || dc_gnt)) begin
            if (exp_q.size() == 0) check("grant_extra", val_t'(1), val_t'(0));
            else check("grant_order", val_t'(dc_gnt), val_t'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver ----------------
    // Samples at the falling edge, then drives the next cycle just after the rising edge.
    task automatic tick();
        @(negedge clk);
        step_check();
        saw_ic = ic_gnt; saw_dc = dc_gnt;
        @(posedge clk); #1;
        if (saw_ic && !ic_hold) ic_req = 0;
        if (saw_dc && !dc_hold) dc_req = 0;
        if (rand_mode) begin
            if (!ic_req && $urandom_range(0, 2) == 0) begin
                ic_req = 1; ic_addr = $urandom;
            end
            if (!dc_req && $urandom_range(0, 2) == 0) begin
                dc_req = 1; dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom; dc_wd = $urandom;
            end
        end
    endtask

    task automatic clear_obs();
        ic_gnt_cyc = -100; ic_val_cyc = -100; dc_gnt_cyc = -100; dc_val_cyc = -100;
        we_cyc = -100; we_cnt = 0; dcv_cnt = 0; we_addr = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int   start;
        val_t saved, tmp;
        logic [31:0] wd;
        for (int i = 0; i < NLINES; i++) ref_mem[i] = init_line(i);
        clear_obs();
        @(posedge clk); #1;
        mem_fill = 1'b0;
        tick();
        tick();
        reset_n = 1;

        // LAT=1: grant in cycle 0, memory in cycle 1, valid in cycle 2.
        l_ic_req = 1; l_ic_addr = 32'h8C;
        @(negedge clk);
        check("l1_ic_gnt", val_t'(l_ic_gnt), val_t'(1));
        check("l1_req_c0", val_t'(l_mem_req), val_t'(0));
        @(posedge clk); #1 l_ic_req = 0;
        @(negedge clk);
        check("l1_gnt_c1", val_t'(l_ic_gnt), val_t'(0));
        check("l1_req_c1", val_t'(l_mem_req), val_t'(1));
        check("l1_addr_c1", val_t'(l_mem_addr), val_t'(32'h80));
        check("l1_valid_c1", val_t'(l_ic_valid), val_t'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_req_c2", val_t'(l_mem_req), val_t'(0));
        check("l1_valid_c2", val_t'(l_ic_valid), val_t'(1));
        check("l1_line", l_ic_line, {32'h80, ~32'h80, 32'h80 ^ 32'h5A5A_5A5A, 32'h0BAD_F00D});
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_busy_c3", val_t'(l_busy), val_t'(0));
        @(posedge clk); #1;
        wd = $urandom;
        l_dc_req = 1; l_dc_we = 1; l_dc_addr = 32'h88; l_dc_wd = wd;
        @(negedge clk);
        check("l1_dc_gnt", val_t'(l_dc_gnt), val_t'(1));
        @(posedge clk); #1 l_dc_req = 0;
        @(negedge clk);
        check("l1_we_c1", val_t'(l_mem_we), val_t'(1));
        check("l1_waddr", val_t'(l_mem_addr), val_t'(32'h88));
        check("l1_wd", val_t'(l_mem_wd), val_t'(wd));
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_we_c2", val_t'(l_mem_we), val_t'(0));
        check("l1_dc_valid", val_t'(l_dc_valid), val_t'(1));
        check("l1_dc_line", l_dc_line, val_t'(0));
        @(posedge clk); #1;

        // Single icache fill at 0x40.
        clear_obs(); start = cyc;
        ic_req = 1; ic_addr = 32'h40;
        repeat (LAT + 3) tick();
        check("t1_gnt_cyc", val_t'(ic_gnt_cyc - start), val_t'(0));
        check("t1_valid_cyc", val_t'(ic_val_cyc - start), val_t'(LAT + 1));
        check("t1_line", ic_line, init_line(4));

        // Both requests in the cycle reset is released: dcache first.
        reset_n = 0; tick();
        clear_obs(); start = cyc;
        reset_n = 1; ic_req = 1; dc_req = 1; dc_we = 0; ic_addr = 32'h50; dc_addr = 32'h64;
        repeat (2 * (LAT + 2) + 1) tick();
        check("t2_dc_gnt_cyc", val_t'(dc_gnt_cyc - start), val_t'(0));
        check("t2_ic_gnt_cyc", val_t'(ic_gnt_cyc - start), val_t'(12));
        check("t2_ic_val_cyc", val_t'(ic_val_cyc - start), val_t'(23));

        // Both held for four accesses: DC, IC, DC, IC.
        reset_n = 0; tick();
        reset_n = 1;
        ic_hold = 1; dc_hold = 1; ic_req = 1; dc_req = 1;
        exp_q = {1'b1, 1'b0, 1'b1, 1'b0};
        track_order = 1;
        repeat (4 * (LAT + 2)) tick();
        track_order = 0;
        check("t3_order_left", val_t'(exp_q.size()), val_t'(0));
        ic_hold = 0; dc_hold = 0; ic_req = 0; dc_req = 0;
        tick();

        // Word write then fill of the same line.
        clear_obs(); start = cyc;
        dc_req = 1; dc_we = 1; dc_addr = 32'h24; dc_wd = 32'hDEAD_BEEF;
        repeat (LAT + 2) tick();
        check("t4_we_cyc", val_t'(we_cyc - start), val_t'(LAT));
        check("t4_we_cnt", val_t'(we_cnt), val_t'(1));
        check("t4_we_addr", val_t'(we_addr), val_t'(32'h24));
        check("t4_valid_cyc", val_t'(dc_val_cyc - start), val_t'(LAT + 1));
        dc_req = 1; dc_we = 0; dc_addr = 32'h20;
        repeat (LAT + 2) tick();
        tmp = dc_line;
        check("t4_word1", val_t'(tmp[63:32]), val_t'(32'hDEAD_BEEF));

        // Reset in cycle 5 of a write.
        saved = mem_arr[3];
        clear_obs();
        dc_req = 1; dc_we = 1; dc_addr = 32'h34; dc_wd = $urandom;
        repeat (5) tick();
        reset_n = 0; tick();
        reset_n = 1;
        repeat (LAT + 3) tick();
        check("t5_no_we", val_t'(we_cnt), val_t'(0));
        check("t5_no_valid", val_t'(dcv_cnt), val_t'(0));
        check("t5_mem_kept", mem_arr[3], saved);

        // Random traffic, then drain pending requests.
        rand_mode = 1;
        repeat (400) tick();
        rand_mode = 0;
        repeat (3 * (LAT + 2)) tick();
        check("drain_idle", val_t'(ic_req | dc_req), val_t'(0));
        for (int i = 0; i < NLINES; i++) check("mem_final", mem_arr[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single backing data memory between the instruction-cache and data-cache miss paths. The block sequences fixed-latency 128-bit line reads and 32-bit word writes, and arbitrates round-robin between the two requesters. It replaces the per-cache blocking wait loops, so the backing memory becomes a purely synchronous slave driven only by this block. It sits between both caches and the memory module.

## Interface
- LAT, 10, memory access latency in cycles; must be ≥1
- LINE_W, 128, line width in bits
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ic_req  in  1  icache line-fill request; held until `ic_gnt`
- ic_addr  in  32  icache fill address; bits [3:0] are ignored
- ic_gnt  out  1  combinational accept strobe, one cycle
- ic_valid  out  1  one-cycle pulse; `ic_line` is valid
- ic_line  out  LINE_W  returned line
- dc_req  in  1  dcache request; held until `dc_gnt`
- dc_we  in  1  1 = word write, 0 = line fill
- dc_addr  in  32  byte address; bits [3:2] select the word for writes
- dc_wd  in  32  write data
- dc_gnt, dc_valid  out  1  same semantics as the icache pair; for writes, `dc_valid` is the write-complete pulse
- dc_line  out  LINE_W  returned line; not updated by writes
- mem_req  out  1  high for the whole access
- mem_we  out  1  write strobe
- mem_addr  out  32  held stable during the access
- mem_wd  out  32  write data
- mem_rdata  in  LINE_W  memory line at `mem_addr`; combinational read
- busy  out  1  high whenever the state is not IDLE

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: the access is in progress for LAT cycles.
  - RESP: one cycle that drives the valid pulse.
- IDLE:
  - If any request is high, select a winner and assert its `*_gnt` in the same cycle.
  - Latch the address, the we flag, the write data and the owner id.
  - Load the counter with LAT-1 and go to BUSY.
- Arbitration, when both requests are high:
  - Grant the requester not served last.
  - The last-served flag resets to "icache", so the dcache wins the first tie after reset.
  - A single requester is always granted.
- BUSY:
  - `mem_req`=1; `mem_addr` is the latched address; `mem_wd` is the latched data.
  - The counter decrements each cycle.
  - When the counter is 0:
    - A fill captures `mem_rdata` into the owner's line register.
    - A write asserts `mem_we` for that cycle only.
  - Then go to RESP.
- RESP:
  - Pulse the owner's `*_valid`.
  - Update the last-served flag.
  - Go to IDLE. No grant is issued in RESP.
- Requests are sampled only in IDLE.
- Deasserting a request during BUSY or RESP has no effect; the access completes.
- A request held through RESP is re-arbitrated in the following IDLE cycle.
- Counter width is $clog2(LAT). With LAT=1, BUSY lasts exactly one cycle.

## Timing
- Reset values:
  - State = IDLE; counter = 0; last-served = icache.
  - All `*_gnt`, `*_valid`, `mem_req`, `mem_we` and `busy` are 0.
  - `ic_line`, `dc_line`, `mem_addr` and `mem_wd` are 0.
- Latency, with the grant in cycle 0:
  - BUSY occupies cycles 1..LAT.
  - `*_valid` is high in cycle LAT+1.
  - The next grant comes no earlier than cycle LAT+2.
- `*_line` holds its value until the next fill for the same owner.
- Reset asserted mid-access:
  - The block returns to IDLE immediately.
  - No valid pulse is issued and `mem_we` does not fire.
  - The memory is left unchanged unless the write edge had already occurred.
- Both requests asserted in the same cycle as reset deassertion: the dcache is granted.

## Structure
- Package `mem_pkg` contains:
  - the `mem_state_t` enum {IDLE, BUSY, RESP};
  - the `req_id_t` enum {REQ_IC, REQ_DC};
  - the LINE_W and LAT default constants.
- Sub-module `rr_arb2`: a 2-way round-robin selector. Inputs are the two requests and the last-served flag; outputs are a one-hot grant and the winner id. It is purely combinational.
- The FSM, counter and latches live in the top module.

## Test plan
- Single icache fill at 0x40 with LAT=10: `ic_gnt` in cycle 0; `mem_req` high in cycles 1–10; `ic_valid` in cycle 11; `ic_line` = the memory line at 0x40.
- Simultaneous `ic_req` and `dc_req` after reset: the dcache is granted first. The icache is granted in cycle 12 and its `ic_valid` arrives in cycle 23.
- Both requests held continuously for 4 accesses: grants alternate DC, IC, DC, IC.
- dcache write of 0xDEADBEEF to 0x24: `mem_we` is high only in cycle 10 with `mem_addr`=0x24; `dc_valid` is high in cycle 11; a subsequent dcache fill of 0x20 returns a line whose word 1 is 0xDEADBEEF.
- `reset_n` pulsed low in cycle 5 of a write: no `mem_we`, no `dc_valid`, all outputs 0, and the memory is unchanged.
- LAT=1: the grant comes in cycle 0, `mem_req` is high only in cycle 1, and `*_valid` is high in cycle 2.
